// File: rtl/loop_engine_pkg.sv
// loop_engine_pkg: shared state type, default loop constants and the accumulator add.
// Defining LOOP_ENGINE_SATURATE_EN makes additions saturate instead of wrapping.
package loop_engine_pkg;
    typedef enum logic {IDLE, RUN} state_t;

    localparam int DEF_WIDTH   = 32;
    localparam int DEF_ITER_W  = 8;
    localparam int DEF_A_STEP  = 10;
    localparam int DEF_B_STEP  = 5;
    localparam int DEF_A_LIMIT = 100;
    localparam int DEF_B_LIMIT = 10;

    // Operands are sign-extended w-bit values; the result is correct in its low w bits.
    function automatic logic signed [63:0] step_add(input logic signed [63:0] x,
                                                    input logic signed [63:0] y,
                                                    input int w);
        logic signed [63:0] s;
`ifdef LOOP_ENGINE_SATURATE_EN
        logic signed [63:0] hi;
        s  = x + y;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        return s > hi ? hi : s < ~hi ? ~hi : s;
`else
        s = x + y;
        return (s <<< (64 - w)) >>> (64 - w);
`endif
    endfunction
endpackage

// File: rtl/loop_engine_step.sv
// loop_step: combinational evaluation of one loop iteration on A and B.
module loop_step
    import loop_engine_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int A_STEP  = DEF_A_STEP,
    parameter int B_STEP  = DEF_B_STEP,
    parameter int A_LIMIT = DEF_A_LIMIT,
    parameter int B_LIMIT = DEF_B_LIMIT
) (
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    output logic signed [WIDTH-1:0] a_nx,
    output logic signed [WIDTH-1:0] b_nx,
    output logic                    brk
);
    localparam logic signed [WIDTH-1:0] A_ST  = WIDTH'(A_STEP);
    localparam logic signed [WIDTH-1:0] B_ST  = WIDTH'(B_STEP);
    localparam logic signed [WIDTH-1:0] A_LIM = WIDTH'(A_LIMIT);
    localparam logic signed [WIDTH-1:0] B_LIM = WIDTH'(B_LIMIT);

    logic a_gt;

    always_comb begin
        a_gt = a > A_LIM;
        brk  = a_gt && b > B_LIM;
        a_nx = a_gt ? a : WIDTH'(step_add(64'(a), 64'(A_ST), WIDTH));
        b_nx = a_gt && !brk ? WIDTH'(step_add(64'(b), 64'(B_ST), WIDTH)) : b;
    end
endmodule

// File: rtl/loop_engine.sv
// loop_engine: runs up to iter_count break/continue loop iterations, one per clock.
// Additions saturate when LOOP_ENGINE_SATURATE_EN is defined, otherwise they wrap.
module loop_engine
    import loop_engine_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int ITER_W  = DEF_ITER_W,
    parameter int A_STEP  = DEF_A_STEP,
    parameter int B_STEP  = DEF_B_STEP,
    parameter int A_LIMIT = DEF_A_LIMIT,
    parameter int B_LIMIT = DEF_B_LIMIT
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [ITER_W-1:0]       iter_count,
    output logic                    busy,
    output logic                    done,
    output logic signed [WIDTH-1:0] a_out,
    output logic signed [WIDTH-1:0] b_out,
    output logic [ITER_W-1:0]       iters_run,
    output logic                    broke
);
    state_t                    state, state_nx;
    logic [ITER_W-1:0]         remaining;
    logic signed [WIDTH-1:0]   a_nx, b_nx;
    logic                      brk, accept, last;

    loop_step #(
        .WIDTH(WIDTH), .A_STEP(A_STEP), .B_STEP(B_STEP),
        .A_LIMIT(A_LIMIT), .B_LIMIT(B_LIMIT)
    ) u_step (
        .a(a_out), .b(b_out), .a_nx(a_nx), .b_nx(b_nx), .brk(brk)
    );

    always_comb begin
        accept   = state == IDLE && start;
        last     = state == RUN && (brk || remaining == ITER_W'(1));
        state_nx = state == IDLE ? (accept && iter_count != '0 ? RUN : IDLE)
                                 : (last ? IDLE : RUN);
        busy     = state == RUN;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            done      <= 1'b0;
            a_out     <= '0;
            b_out     <= '0;
            iters_run <= '0;
            broke     <= 1'b0;
            remaining <= '0;
        end else begin
            done <= (accept && iter_count == '0) || last;
            if (accept) begin
                a_out     <= '0;
                b_out     <= '0;
                iters_run <= '0;
                broke     <= 1'b0;
                remaining <= iter_count;
            end else if (state == RUN) begin
                a_out     <= a_nx;
                b_out     <= b_nx;
                iters_run <= iters_run + ITER_W'(1);
                broke     <= brk;
                remaining <= remaining - ITER_W'(1);
            end
        end
endmodule

// File: tb/tb_loop_engine.sv
// tb_loop_engine: directed runs with a scoreboard of expected results popped on each done.
module tb_loop_engine;
    typedef struct {
        longint a, b, it, br, cyc;
    } exp_t;

    logic               clk, rst_n, start, start8;
    logic [7:0]         iter_count, iter8;
    logic               busy, done, broke, busy8, done8, broke8;
    logic signed [31:0] a_out, b_out;
    logic signed [7:0]  a8, b8;
    logic [7:0]         iters_run, iters8;
    int                 cyc, checks, errors;
    exp_t               q[$];

    loop_engine dut (
        .clk(clk), .rst_n(rst_n), .start(start), .iter_count(iter_count),
        .busy(busy), .done(done), .a_out(a_out), .b_out(b_out),
        .iters_run(iters_run), .broke(broke)
    );

    loop_engine #(.WIDTH(8), .A_STEP(100), .A_LIMIT(127)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .iter_count(iter8),
        .busy(busy8), .done(done8), .a_out(a8), .b_out(b8),
        .iters_run(iters8), .broke(broke8)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    always @(negedge clk)
        if (done) begin
            if (q.size() == 0) chk("spurious_done", 64'(done), 0);
            else begin
                exp_t e;
                e = q.pop_front();
                chk("done_cycle", cyc, e.cyc);
                chk("a_out", a_out, e.a);
                chk("b_out", b_out, e.b);
                chk("iters_run", 64'(iters_run), e.it);
                chk("broke", 64'(broke), e.br);
            end
        end

    task automatic wait_done();
        for (int i = 0; i < 100 && q.size() != 0; i++) @(posedge clk);
        chk("done_timeout", q.size(), 0);
        @(negedge clk);
    endtask

    task automatic run(input int n, input longint ea, input longint eb,
                       input longint eit, input longint ebr, input int lat);
        q.push_back('{ea, eb, eit, ebr, longint'(cyc + 1 + lat)});
        start = 1;
        iter_count = 8'(n);
        @(negedge clk);
        start = 0;
        chk("busy_after_start", 64'(busy), 64'(n != 0));
        wait_done();
        chk("busy_after_done", 64'(busy), 0);
    endtask

    initial begin
        cyc = 0; checks = 0; errors = 0;
        rst_n = 0; start = 0; iter_count = 0; start8 = 0; iter8 = 0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_done", 64'(done), 0);
        chk("rst_a", a_out, 0);
        chk("rst_b", b_out, 0);
        chk("rst_iters", 64'(iters_run), 0);
        chk("rst_broke", 64'(broke), 0);
        rst_n = 1;
        @(negedge clk);

        run(15, 110, 15, 15, 1, 15);
        run(14, 110, 15, 14, 0, 14);
        run(0, 0, 0, 0, 0, 0);

        // N=20 breaks at iteration 15; starts during RUN must be ignored
        q.push_back('{110, 15, 15, 1, longint'(cyc + 16)});
        start = 1;
        iter_count = 20;
        @(negedge clk);
        for (int i = 1; i < 15; i++) begin
            chk("busy_in_run", 64'(busy), 1);
            start = (i == 3 || i == 7);
            iter_count = 8'(i);
            @(negedge clk);
        end
        start = 0;
        wait_done();
        chk("busy_after_break", 64'(busy), 0);

        // asynchronous reset mid-run
        q.push_back('{110, 15, 15, 1, longint'(cyc + 16)});
        start = 1;
        iter_count = 15;
        @(negedge clk);
        start = 0;
        repeat (4) @(negedge clk);
        chk("pre_rst_a", a_out, 40);
        #2 rst_n = 0;
        #1;
        chk("mid_rst_a", a_out, 0);
        chk("mid_rst_b", b_out, 0);
        chk("mid_rst_iters", 64'(iters_run), 0);
        chk("mid_rst_busy", 64'(busy), 0);
        q.delete();
        @(negedge clk);
        rst_n = 1;
        repeat (20) @(negedge clk);
        run(15, 110, 15, 15, 1, 15);

        // narrow instance: A overflows on the second step
        start8 = 1;
        iter8 = 2;
        @(negedge clk);
        start8 = 0;
        for (int i = 0; i < 20 && !done8; i++) @(negedge clk);
        chk("w8_done", 64'(done8), 1);
`ifdef LOOP_ENGINE_SATURATE_EN
        chk("w8_a", a8, 127);
`else
        chk("w8_a", a8, -56);
`endif
        chk("w8_b", b8, 0);
        chk("w8_iters", 64'(iters8), 2);
        chk("w8_broke", 64'(broke8), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
